// File: rtl/memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// memory_access_unit_pkg / memory_access_unit_if
//
// Purpose:
//   Shared cache-request enums and the signal bundle that connects the
//   load/store unit to the execute stage (in_*), the writeback stage (out_*)
//   and the data cache (req_*).
//
// Modports:
//   master : the load/store unit itself (drives in_ready, out_*, req_* except
//            the cache return path).
//   slave  : the surrounding pipeline and cache (drives in_*, out_ready,
//            req_loaded_word, req_fulfilled).
//
// Handshake rules (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once valid is raised, the payload stays stable and valid stays high until
//   that transfer completes. The cache channel has no ready: req_valid and the
//   req_* payload stay stable until the cache pulses req_fulfilled (or the
//   unit's watchdog aborts the request).
// -----------------------------------------------------------------------------
package memory_access_unit_pkg;
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } memory_operation_size_e;
endpackage

interface memory_access_unit_if #(
    parameter int XLEN = 32
);
    import memory_access_unit_pkg::*;

    // execute -> unit
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_is_store;
    logic [2:0]             in_funct3;
    logic [XLEN-1:0]        in_address;
    logic [XLEN-1:0]        in_store_data;

    // unit -> writeback
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_load_data;
    logic                   out_misaligned;
    logic                   out_illegal;
    logic                   out_timeout;

    // unit <-> data cache
    logic [XLEN-1:0]        req_address;
    memory_operation_e      req_operation;
    memory_operation_size_e req_size;
    logic [XLEN-1:0]        req_store_word;
    logic                   req_valid;
    logic [XLEN-1:0]        req_loaded_word;
    logic                   req_fulfilled;

    modport master (
        input  in_valid, in_is_store, in_funct3, in_address, in_store_data,
        output in_ready,
        output out_valid, out_load_data, out_misaligned, out_illegal, out_timeout,
        input  out_ready,
        output req_address, req_operation, req_size, req_store_word, req_valid,
        input  req_loaded_word, req_fulfilled
    );

    modport slave (
        output in_valid, in_is_store, in_funct3, in_address, in_store_data,
        input  in_ready,
        input  out_valid, out_load_data, out_misaligned, out_illegal, out_timeout,
        output out_ready,
        input  req_address, req_operation, req_size, req_store_word, req_valid,
        output req_loaded_word, req_fulfilled
    );
endinterface

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
//
// Purpose:
//   Load/store stage in front of the data cache. Accepts one memory micro-op,
//   decodes RISC-V funct3, checks alignment, issues a held cache request,
//   extends load data and returns a completion with misaligned / illegal /
//   timeout flags.
//
// Ports:
//   clk          : clock
//   reset        : asynchronous active-high reset
//   bus          : memory_access_unit_if.master (execute, writeback, cache)
//   o_dbg_state  : current FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Parameters:
//   XLEN           : data/address width, must match the interface XLEN
//   TIMEOUT_CYCLES : max cycles spent in REQ before abort, 0 disables it
// -----------------------------------------------------------------------------
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    memory_access_unit_if.master bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] WD_LAST = WD_LAST_INT[CW-1:0];

    state_e                 r_state;
    logic [XLEN-1:0]        r_address;
    memory_operation_e      r_operation;
    memory_operation_size_e r_size;
    logic                   r_unsigned;
    logic [XLEN-1:0]        r_store_word;
    logic                   r_req_valid;
    logic                   r_out_valid;
    logic [XLEN-1:0]        r_load_data;
    logic                   r_misaligned;
    logic                   r_illegal;
    logic                   r_timeout;
    logic [CW-1:0]          r_wdog;

    logic                   w_legal;
    logic                   w_unsigned;
    memory_operation_size_e w_size;
    logic                   w_misaligned;
    logic [XLEN-1:0]        w_store_word;
    logic [XLEN-1:0]        w_ext;

    // Decode of the incoming op; only consumed on the accepting edge.
    always_comb begin
        w_legal    = 1'b0;
        w_unsigned = 1'b0;
        w_size     = SIZE_BYTE;
        if (bus.in_is_store) begin
            case (bus.in_funct3)
                3'b000:  begin w_legal = 1'b1; w_size = SIZE_BYTE; end
                3'b001:  begin w_legal = 1'b1; w_size = SIZE_HALF; end
                3'b010:  begin w_legal = 1'b1; w_size = SIZE_WORD; end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (bus.in_funct3)
                3'b000:  begin w_legal = 1'b1; w_size = SIZE_BYTE; end
                3'b001:  begin w_legal = 1'b1; w_size = SIZE_HALF; end
                3'b010:  begin w_legal = 1'b1; w_size = SIZE_WORD; end
                3'b100:  begin w_legal = 1'b1; w_size = SIZE_BYTE; w_unsigned = 1'b1; end
                3'b101:  begin w_legal = 1'b1; w_size = SIZE_HALF; w_unsigned = 1'b1; end
                default: w_legal = 1'b0;
            endcase
        end

        // Gated by w_legal so an illegal op never reports misalignment too.
        w_misaligned = w_legal &&
                       (((w_size == SIZE_HALF) && bus.in_address[0]) ||
                        ((w_size == SIZE_WORD) && (bus.in_address[1:0] != 2'b00)));

        case (w_size)
            SIZE_BYTE: w_store_word = {{(XLEN-8){1'b0}},  bus.in_store_data[7:0]};
            SIZE_HALF: w_store_word = {{(XLEN-16){1'b0}}, bus.in_store_data[15:0]};
            default:   w_store_word = bus.in_store_data;
        endcase
    end

    // Extension of the cache return data; stores complete with zero.
    always_comb begin
        w_ext = bus.req_loaded_word;
        if (r_operation == MEM_STORE) begin
            w_ext = '0;
        end else begin
            case (r_size)
                SIZE_BYTE: w_ext = r_unsigned ? {{(XLEN-8){1'b0}}, bus.req_loaded_word[7:0]}
                                              : {{(XLEN-8){bus.req_loaded_word[7]}}, bus.req_loaded_word[7:0]};
                SIZE_HALF: w_ext = r_unsigned ? {{(XLEN-16){1'b0}}, bus.req_loaded_word[15:0]}
                                              : {{(XLEN-16){bus.req_loaded_word[15]}}, bus.req_loaded_word[15:0]};
                default:   w_ext = bus.req_loaded_word;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_address    <= '0;
            r_operation  <= MEM_LOAD;
            r_size       <= SIZE_BYTE;
            r_unsigned   <= 1'b0;
            r_store_word <= '0;
            r_req_valid  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_load_data <= '0;
                        r_wdog      <= '0;
                        if (!w_legal) begin
                            r_illegal   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_address    <= bus.in_address;
                            r_operation  <= bus.in_is_store ? MEM_STORE : MEM_LOAD;
                            r_size       <= w_size;
                            r_unsigned   <= w_unsigned;
                            r_store_word <= w_store_word;
                            r_req_valid  <= 1'b1;
                            r_state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Fulfilment is checked first so it wins on the limit cycle.
                    if (bus.req_fulfilled) begin
                        r_req_valid <= 1'b0;
                        r_load_data <= w_ext;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_wdog == WD_LAST)) begin
                        r_req_valid <= 1'b0;
                        r_load_data <= '0;
                        r_timeout   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_load_data  <= '0;
                        r_misaligned <= 1'b0;
                        r_illegal    <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == S_IDLE);
    assign bus.out_valid      = r_out_valid;
    assign bus.out_load_data  = r_load_data;
    assign bus.out_misaligned = r_misaligned;
    assign bus.out_illegal    = r_illegal;
    assign bus.out_timeout    = r_timeout;
    assign bus.req_address    = r_address;
    assign bus.req_operation  = r_operation;
    assign bus.req_size       = r_size;
    assign bus.req_store_word = r_store_word;
    assign bus.req_valid      = r_req_valid;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
//
// Self-checking bench: directed ops from the test plan followed by random
// ops, each checked against a reference computed from the funct3 rules with
// plain arithmetic. Watchdog limit is 16 cycles.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    memory_access_unit_if #(.XLEN(XLEN)) bus ();

    memory_access_unit #(
        .XLEN(XLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN+2:0] exp_q[$];   // {timeout, illegal, misaligned, load_data}

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          illegal;
        bit          mis;
        int          size_code;
        logic [31:0] sw;
        logic [31:0] ld;
    } model_t;

    function automatic model_t model(input bit st, input int f3, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [31:0] loaded);
        model_t m;
        int     bytes;
        longint a, d, l, lim, v;
        a = addr;
        d = data;
        l = loaded;
        m.illegal   = st ? (f3 > 2) : !(f3 inside {0, 1, 2, 4, 5});
        m.mis       = 1'b0;
        m.size_code = 0;
        m.sw        = '0;
        m.ld        = '0;
        if (!m.illegal) begin
            bytes       = 1 << (f3 % 4);
            m.size_code = (bytes == 1) ? 0 : (bytes == 2) ? 1 : 2;
            m.mis       = (a % bytes) != 0;
            lim         = longint'(1) << (8 * bytes);
            v           = d % lim;
            m.sw        = v[31:0];
            if (!st) begin
                v = l % lim;
                if (f3 < 4 && bytes < 4 && v >= lim / 2) v = v - lim;
                m.ld = v[31:0];
            end
        end
        return m;
    endfunction

    function automatic logic [XLEN+2:0] observed();
        return {bus.out_timeout, bus.out_illegal, bus.out_misaligned, bus.out_load_data};
    endfunction

    // ---------------- driver ----------------
    // latency: REQ cycle (1-based) in which the cache pulses req_fulfilled
    // hold:    cycles with out_ready low before accepting the completion
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] loaded,
                         input int latency, input int hold);
        model_t          m;
        int              waited;
        bit              faulted;
        bit              tmo;
        logic [XLEN+2:0] exp;

        m = model(st, int'(f3), addr, data, loaded);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready_before_op", bus.in_ready, 1);

        bus.in_valid      = 1'b1;
        bus.in_is_store   = st;
        bus.in_funct3     = f3;
        bus.in_address    = addr;
        bus.in_store_data = data;
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.in_address    = $urandom();
        bus.in_store_data = $urandom();

        faulted = m.illegal || m.mis;
        tmo     = !faulted && (latency > TMO);
        exp_q.push_back({tmo, m.illegal, m.mis && !m.illegal, (faulted || tmo) ? 32'h0 : m.ld});

        if (faulted) begin
            chk("fault_no_req", bus.req_valid, 0);
        end else begin
            chk("state_req", dbg_state, 1);
            for (int i = 1; i <= TMO; i++) begin
                chk("req_valid", bus.req_valid, 1);
                chk("req_address", bus.req_address, addr);
                chk("req_operation", logic'(bus.req_operation), st);
                chk("req_size", bus.req_size, m.size_code);
                chk("req_store_word", bus.req_store_word, m.sw);
                chk("out_valid_in_req", bus.out_valid, 0);
                bus.req_fulfilled   = (i == latency);
                bus.req_loaded_word = (i == latency) ? loaded : $urandom();
                @(posedge clk); #1;
                bus.req_fulfilled = 1'b0;
                if (i == latency) break;
            end
            chk("req_dropped", bus.req_valid, 0);
        end

        exp = exp_q.pop_front();
        chk("out_valid", bus.out_valid, 1);
        chk("result", observed(), exp);

        for (int h = 0; h < hold; h++) begin
            // Noise on the cache return must be ignored outside REQ.
            bus.req_fulfilled   = 1'b1;
            bus.req_loaded_word = $urandom();
            @(posedge clk); #1;
            bus.req_fulfilled = 1'b0;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_result", observed(), exp);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_no_req", bus.req_valid, 0);
        end

        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_cleared", bus.out_valid, 0);
        chk("flags_cleared", observed(), 0);
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset               = 1'b1;
        bus.in_valid        = 1'b0;
        bus.in_is_store     = 1'b0;
        bus.in_funct3       = 3'b000;
        bus.in_address      = '0;
        bus.in_store_data   = '0;
        bus.out_ready       = 1'b0;
        bus.req_loaded_word = '0;
        bus.req_fulfilled   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_outputs", observed(), 0);
        chk("rst_req_address", bus.req_address, 0);
        chk("rst_req_store_word", bus.req_store_word, 0);
        chk("rst_state", dbg_state, 0);

        // Directed cases
        do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h0000_00F0, 2,  0); // LB  -> FFFFFFF0
        do_op(1'b0, 3'b100, 32'h0000_1003, 32'h0,         32'h0000_00F0, 2,  0); // LBU -> 000000F0
        do_op(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1234_5678, 1,  0); // SH  -> BEEF
        do_op(1'b0, 3'b010, 32'h0000_1002, 32'h0,         32'h0,         1,  0); // LW misaligned
        do_op(1'b0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,         1,  0); // illegal load
        do_op(1'b1, 3'b100, 32'h0000_1001, 32'h0,         32'h0,         1,  0); // illegal beats misaligned
        do_op(1'b0, 3'b010, 32'h0000_0040, 32'h0,         32'h5555_5555, 99, 0); // timeout
        do_op(1'b0, 3'b010, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 16, 0); // fulfil on limit
        do_op(1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'h0000_8001, 1,  5); // LH, held 5 cycles
        do_op(1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'hABCD_8001, 3,  0); // LHU
        do_op(1'b1, 3'b010, 32'h0000_0020, 32'h8765_4321, 32'hFFFF_FFFF, 1,  0); // SW

        // Reset in the middle of a request
        bus.in_valid    = 1'b1;
        bus.in_is_store = 1'b0;
        bus.in_funct3   = 3'b010;
        bus.in_address  = 32'h0000_0100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pre_reset_req_valid", bus.req_valid, 1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_req_valid", bus.req_valid, 0);
        chk("mid_reset_out_valid", bus.out_valid, 0);
        chk("mid_reset_state", dbg_state, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_fulfilled   = 1'b1;
        bus.req_loaded_word = 32'h1111_2222;
        @(posedge clk); #1;
        bus.req_fulfilled = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_reset_no_out", bus.out_valid, 0);
            chk("post_reset_in_ready", bus.in_ready, 1);
            @(posedge clk); #1;
        end

        // Random ops
        for (int n = 0; n < 40; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          lat;
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom();
            lat  = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 4);
            do_op(st, f3, addr, $urandom(), $urandom(), lat, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL global_timeout: got stalled expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
